// File: rtl/io_port_arbiter_pkg.sv
// io_arb_pkg
// Shared definitions for the IO port arbiter:
//   - FSM state codes (IDLE, CMD, RWAIT, DONE) as fixed 2-bit constants
//   - IO port register addresses (status, led, switch low/high)
//   - cmd_t: the command latched from the winning master at grant time
// The command struct is sized by IO_ADDR_W/IO_DATA_W, which are also the
// default bus widths of io_port_arbiter.
package io_arb_pkg;

   localparam int IO_ADDR_W = 2;
   localparam int IO_DATA_W = 32;

   // Arbiter FSM state encoding.
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] CMD   = 2'd1;
   localparam logic [1:0] RWAIT = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   // IO port register map.
   localparam logic [IO_ADDR_W-1:0] IO_STATUS = 2'b00;
   localparam logic [IO_ADDR_W-1:0] IO_LED    = 2'b01;
   localparam logic [IO_ADDR_W-1:0] IO_SW_LO  = 2'b10;
   localparam logic [IO_ADDR_W-1:0] IO_SW_HI  = 2'b11;

   typedef struct packed {
      logic                 we;
      logic [IO_ADDR_W-1:0] addr;
      logic [IO_DATA_W-1:0] wdata;
   } cmd_t;

endpackage

// File: rtl/io_port_arbiter_rr_arb2.sv
// rr_arb2
// Two-requester arbiter with a remembered last grant.
//   clk, rst    : clock, synchronous active-high reset
//   req[1:0]    : eligible requests this cycle
//   take        : 1 when the grant is actually consumed (updates last_grant)
//   grant[1:0]  : one-hot grant, combinational from req and last_grant
//   last_grant  : index of the most recently granted requester (reset: 1,
//                 so requester 0 wins the first contest)
// FIXED_PRIO=1 makes requester 0 win every contest; otherwise a contest goes
// to the requester that was not granted last.
module rr_arb2 #(
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       take,
   output logic [1:0] grant,
   output logic       last_grant
);

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the case can leave it unassigned and infer a latch.
   always_comb begin
      grant = 2'b00;
      unique case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11: begin
            if (FIXED_PRIO) grant = 2'b01;
            else            grant = last_grant ? 2'b01 : 2'b10;
         end
         default: grant = 2'b00;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples pre-edge values, independent of block ordering.
   always_ff @(posedge clk) begin
      if (rst)                last_grant <= 1'b1;
      else if (take && |grant) last_grant <= grant[1];
   end

endmodule

// File: rtl/io_port_arbiter.sv
// io_port_arbiter
// Shares the single IO port bus between the CPU data path (master 0) and an
// auxiliary master (master 1). One command is latched per grant, the port is
// strobed for exactly one cycle, and a registered one-cycle ack (with read
// data for reads) goes back to the owning master.
//   clk, rst                     : clock, synchronous active-high reset
//   mN_req/we/addr/wdata         : master N command, held until mN_ack
//   mN_ack                       : one-cycle completion pulse
//   mN_rdata                     : read data, valid with mN_ack, then held
//   p_read/p_write               : port strobes (one cycle per transaction)
//   p_addr/p_wdata               : port address / write data (held between)
//   p_rdata                      : port read data, valid cycle after p_read
//   busy                         : 1 whenever the FSM is not idle
//   owner                        : current / last granted master
// Sequence: IDLE -> CMD -> DONE (write) or IDLE -> CMD -> RWAIT -> DONE
// (read). The ack becomes visible in the IDLE cycle after DONE, which is why
// a master's own request is masked while its ack is high.
module io_port_arbiter
   import io_arb_pkg::*;
#(
   parameter int ADDR_W     = IO_ADDR_W,
   parameter int DATA_W     = IO_DATA_W,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              p_read,
   output logic              p_write,
   output logic [ADDR_W-1:0] p_addr,
   output logic [DATA_W-1:0] p_wdata,
   input  logic [DATA_W-1:0] p_rdata,
   output logic              busy,
   output logic              owner
);

   logic [1:0] state;
   logic [1:0] elig;
   logic [1:0] grant;
   logic       take;
   logic       last_grant;
   cmd_t       win_cmd;
   cmd_t       cmd;

   // A master is not eligible in its own ack cycle: its req is still high
   // from the finished transaction and must not start a duplicate.
   assign elig = {m1_req & ~m1_ack, m0_req & ~m0_ack};
   assign take = (state == IDLE);

   rr_arb2 #(
      .FIXED_PRIO (FIXED_PRIO)
   ) u_arb (
      .clk        (clk),
      .rst        (rst),
      .req        (elig),
      .take       (take),
      .grant      (grant),
      .last_grant (last_grant)
   );

   // last_grant is a flop updated at the grant edge, so owner is registered.
   assign owner = last_grant;

   always_comb begin
      win_cmd = cmd_t'{we: m0_we, addr: m0_addr, wdata: m0_wdata};
      if (grant[1]) win_cmd = cmd_t'{we: m1_we, addr: m1_addr, wdata: m1_wdata};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cmd      <= '0;
         p_read   <= 1'b0;
         p_write  <= 1'b0;
         p_addr   <= '0;
         p_wdata  <= '0;
         m0_ack   <= 1'b0;
         m1_ack   <= 1'b0;
         m0_rdata <= '0;
         m1_rdata <= '0;
         busy     <= 1'b0;
      end else begin
         m0_ack <= 1'b0;
         m1_ack <= 1'b0;
         unique case (state)
            IDLE: begin
               if (|grant) begin
                  // Strobes and address are registered here so they are
                  // visible exactly during the CMD cycle.
                  cmd     <= win_cmd;
                  p_write <= win_cmd.we;
                  p_read  <= ~win_cmd.we;
                  p_addr  <= win_cmd.addr;
                  p_wdata <= win_cmd.wdata;
                  busy    <= 1'b1;
                  state   <= CMD;
               end
            end
            CMD: begin
               p_read  <= 1'b0;
               p_write <= 1'b0;
               state   <= cmd.we ? DONE : RWAIT;
            end
            RWAIT: begin
               // The port registers its data, so p_rdata is valid now.
               if (owner) m1_rdata <= p_rdata;
               else       m0_rdata <= p_rdata;
               state <= DONE;
            end
            DONE: begin
               m0_ack <= ~owner;
               m1_ack <= owner;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
